// File: rtl/f3_puzzle_engine.sv
// 4x4 sliding-tile board driven by function-3 key commands, with an
// LFSR-driven scramble sequence and a registered tile read port.
module f3_puzzle_engine #(
  parameter int unsigned SCRAMBLE_MOVES = 64,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        write,
  input  logic [3:0]  instruction,
  input  logic [3:0]  rd_addr,
  output logic [3:0]  rd_tile,
  output logic [3:0]  blank_pos,
  output logic        busy,
  output logic        solved,
  output logic [15:0] move_count
);

  typedef enum logic {IDLE, SCRAMBLE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  board_q [16];
  logic [3:0]  board_d [16];
  logic [3:0]  blank_q, blank_d;
  logic [15:0] move_count_q, move_count_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] scr_cnt_q, scr_cnt_d;
  logic        write_prev_q, write_prev_d;
  logic [3:0]  rd_tile_q, rd_tile_d;

  logic        accept;
  logic        mv_en;
  logic [1:0]  mv_dir;
  logic        mv_legal;
  logic [3:0]  mv_target;

  // Direction encoding is the blank's travel: 0 N, 1 E, 2 W, 3 S.
  always_comb begin
    mv_legal  = 1'b0;
    mv_target = blank_q;
    case (mv_dir)
      2'd0: begin mv_legal = (blank_q >= 4'd4);      mv_target = blank_q - 4'd4; end
      2'd1: begin mv_legal = (blank_q[1:0] != 2'd3); mv_target = blank_q + 4'd1; end
      2'd2: begin mv_legal = (blank_q[1:0] != 2'd0); mv_target = blank_q - 4'd1; end
      default: begin mv_legal = (blank_q <= 4'd11); mv_target = blank_q + 4'd4; end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    blank_d      = blank_q;
    move_count_d = move_count_q;
    lfsr_d       = lfsr_q;
    scr_cnt_d    = scr_cnt_q;
    write_prev_d = write;
    rd_tile_d    = board_q[rd_addr];
    for (int i = 0; i < 16; i++) board_d[i] = board_q[i];
    accept = write & ~write_prev_q;
    mv_en  = 1'b0;
    mv_dir = 2'd0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (instruction)
            4'd1: begin mv_en = 1'b1; mv_dir = 2'd0; end
            4'd2: begin mv_en = 1'b1; mv_dir = 2'd1; end
            4'd3: begin mv_en = 1'b1; mv_dir = 2'd2; end
            4'd4: begin mv_en = 1'b1; mv_dir = 2'd3; end
            4'd5: begin state_d = SCRAMBLE; scr_cnt_d = 16'd0; end
            default: ;
          endcase
        end
      end
      default: begin
        // Fibonacci taps 16,14,13,11; the current value picks this cycle's move.
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        mv_en  = 1'b1;
        mv_dir = lfsr_q[1:0];
      end
    endcase

    if (mv_en && mv_legal) begin
      board_d[blank_q]   = board_q[mv_target];
      board_d[mv_target] = 4'd0;
      blank_d            = mv_target;
      if (state_q == IDLE) begin
        if (move_count_q != 16'hFFFF) move_count_d = move_count_q + 16'd1;
      end else begin
        scr_cnt_d = scr_cnt_q + 16'd1;
        if (scr_cnt_d == 16'(SCRAMBLE_MOVES)) begin
          state_d      = IDLE;
          move_count_d = 16'd0;
        end
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      blank_q      <= 4'd15;
      move_count_q <= 16'd0;
      lfsr_q       <= LFSR_SEED;
      scr_cnt_q    <= 16'd0;
      write_prev_q <= 1'b0;
      rd_tile_q    <= 4'd0;
      for (int i = 0; i < 16; i++) board_q[i] <= (i == 15) ? 4'd0 : 4'(i + 1);
    end else begin
      state_q      <= state_d;
      blank_q      <= blank_d;
      move_count_q <= move_count_d;
      lfsr_q       <= lfsr_d;
      scr_cnt_q    <= scr_cnt_d;
      write_prev_q <= write_prev_d;
      rd_tile_q    <= rd_tile_d;
      for (int i = 0; i < 16; i++) board_q[i] <= board_d[i];
    end
  end

  always_comb begin
    solved = (board_q[15] == 4'd0);
    for (int i = 0; i < 15; i++) begin
      if (board_q[i] != 4'(i + 1)) solved = 1'b0;
    end
  end

  assign rd_tile    = rd_tile_q;
  assign blank_pos  = blank_q;
  assign busy       = (state_q == SCRAMBLE);
  assign move_count = move_count_q;

endmodule

// File: tb/tb_f3_puzzle_engine.sv
// Directed bench for f3_puzzle_engine: reference board model plus a
// read-port scoreboard of expected tiles.
module tb_f3_puzzle_engine;

  logic        sysclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  instruction = 4'd0;
  logic [3:0]  rd_addr = 4'd0;
  logic [3:0]  rd_tile;
  logic [3:0]  blank_pos;
  logic        busy;
  logic        solved;
  logic [15:0] move_count;

  f3_puzzle_engine #(.SCRAMBLE_MOVES(64), .LFSR_SEED(16'hACE1)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .write(write), .instruction(instruction),
    .rd_addr(rd_addr), .rd_tile(rd_tile), .blank_pos(blank_pos), .busy(busy),
    .solved(solved), .move_count(move_count)
  );

  always #5 sysclk = ~sysclk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [3:0]  exp_q [$];
  logic [3:0]  model [16];
  logic [3:0]  mblank;
  logic [15:0] mcount;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = (i == 15) ? 4'd0 : 4'(i + 1);
    mblank = 4'd15;
    mcount = 16'd0;
  endtask

  task automatic model_move(input int dir);
    int b;
    int t;
    bit ok;
    b  = int'(mblank);
    ok = 1'b0;
    t  = b;
    case (dir)
      0: begin ok = (b >= 4);      t = b - 4; end
      1: begin ok = (b % 4 != 3);  t = b + 1; end
      2: begin ok = (b % 4 != 0);  t = b - 1; end
      default: begin ok = (b <= 11); t = b + 4; end
    endcase
    if (ok) begin
      model[b] = model[t];
      model[t] = 4'd0;
      mblank   = 4'(t);
      if (mcount != 16'hFFFF) mcount = mcount + 16'd1;
    end
  endtask

  function automatic logic model_solved();
    logic s;
    s = (model[15] == 4'd0);
    for (int i = 0; i < 15; i++) if (model[i] != 4'(i + 1)) s = 1'b0;
    return s;
  endfunction

  task automatic check_status(input string tag);
    chk({tag, "_blank"}, 32'(blank_pos), 32'(mblank));
    chk({tag, "_count"}, 32'(move_count), 32'(mcount));
    chk({tag, "_solved"}, 32'(solved), 32'(model_solved()));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Scoreboard read sweep: expected tile queued when the address is driven,
  // popped one cycle later when rd_tile carries it.
  task automatic check_board(input string tag);
    for (int i = 0; i <= 16; i++) begin
      @(negedge sysclk);
      if (i > 0) chk($sformatf("%s_tile%0d", tag, i - 1), 32'(rd_tile), 32'(exp_q.pop_front()));
      if (i < 16) begin
        rd_addr = 4'(i);
        exp_q.push_back(model[i]);
      end
    end
  endtask

  task automatic read_board(output logic [63:0] packed_b);
    packed_b = '0;
    for (int i = 0; i <= 16; i++) begin
      @(negedge sysclk);
      if (i > 0) packed_b[(i - 1) * 4 +: 4] = rd_tile;
      if (i < 16) rd_addr = 4'(i);
    end
  endtask

  task automatic check_perm(input string tag, input logic [63:0] b);
    logic [15:0] seen;
    seen = '0;
    for (int i = 0; i < 16; i++) seen[b[i * 4 +: 4]] = 1'b1;
    chk({tag, "_perm"}, 32'(seen), 32'h0000FFFF);
    chk({tag, "_blank_zero"}, 32'(b[blank_pos * 4 +: 4]), 32'd0);
  endtask

  task automatic press(input logic [3:0] instr, input int hold);
    @(negedge sysclk);
    write = 1'b1;
    instruction = instr;
    repeat (hold) @(negedge sysclk);
    write = 1'b0;
    case (instr)
      4'd1: model_move(0);
      4'd2: model_move(1);
      4'd3: model_move(2);
      4'd4: model_move(3);
      default: ;
    endcase
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    rst_n = 1'b0;
    repeat (2) @(negedge sysclk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_idle(input string tag, output int cycles);
    int guard;
    guard  = 0;
    cycles = 0;
    while (busy && guard < 3000) begin
      @(negedge sysclk);
      cycles++;
      guard++;
    end
    chk({tag, "_timeout"}, 32'(busy), 32'd0);
  endtask

  logic [63:0] b1, b2;
  int          busy_cycles;
  int          guard;

  initial begin
    do_reset();
    check_status("reset");
    check_board("home");

    press(4'd1, 10);
    chk("north_held_blank", 32'(blank_pos), 32'd11);
    chk("north_held_count", 32'(move_count), 32'd1);
    chk("north_held_solved", 32'(solved), 32'd0);
    check_status("north_held");
    check_board("north_held");

    press(4'd4, 1);
    chk("south_back_count", 32'(move_count), 32'd2);
    check_status("south_back");
    check_board("south_back");

    do_reset();
    press(4'd2, 1);
    press(4'd4, 1);
    press(4'd0, 1);
    press(4'd9, 1);
    chk("edge_ignored_count", 32'(move_count), 32'd0);
    check_status("edge_ignored");
    check_board("edge_ignored");

    press(4'd3, 1);
    press(4'd3, 1);
    press(4'd3, 1);
    press(4'd3, 1);
    chk("west_wrap_blank", 32'(blank_pos), 32'd12);
    chk("west_wrap_count", 32'(move_count), 32'd3);
    check_status("west_wrap");
    check_board("west_wrap");
    press(4'd1, 1);
    check_status("north_from12");
    check_board("north_from12");

    do_reset();
    @(negedge sysclk);
    force dut.move_count_q = 16'hFFFE;
    @(negedge sysclk);
    release dut.move_count_q;
    @(negedge sysclk);
    mcount = 16'hFFFE;
    chk("sat_preset", 32'(move_count), 32'h0000FFFE);
    press(4'd1, 1);
    chk("sat_1", 32'(move_count), 32'h0000FFFF);
    press(4'd4, 1);
    chk("sat_2", 32'(move_count), 32'h0000FFFF);
    press(4'd1, 1);
    chk("sat_3", 32'(move_count), 32'h0000FFFF);
    check_status("sat");

    do_reset();
    @(negedge sysclk);
    write = 1'b1;
    instruction = 4'd5;
    @(negedge sysclk);
    busy_cycles = 0;
    guard = 0;
    while (busy && guard < 3000) begin
      busy_cycles++;
      if (busy_cycles < 40) begin
        write = busy_cycles[1];
        instruction = busy_cycles[2] ? 4'd5 : 4'd2;
      end else begin
        write = 1'b1;
        instruction = 4'd1;
      end
      @(negedge sysclk);
      guard++;
    end
    chk("scr1_timeout", 32'(busy), 32'd0);
    chk("scr1_min_busy", 32'(busy_cycles >= 64), 32'd1);
    repeat (2) @(negedge sysclk);
    chk("scr1_held_key_count", 32'(move_count), 32'd0);
    chk("scr1_held_key_busy", 32'(busy), 32'd0);
    write = 1'b0;
    read_board(b1);
    check_perm("scr1", b1);

    press(4'd5, 1);
    wait_idle("scr2", busy_cycles);
    chk("scr2_count", 32'(move_count), 32'd0);
    read_board(b2);
    check_perm("scr2", b2);
    chk("scr2_differs", 32'(b1 !== b2), 32'd1);

    press(4'd5, 1);
    repeat (10) @(negedge sysclk);
    chk("midreset_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge sysclk);
    rst_n = 1'b1;
    model_reset();
    chk("midreset_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
    check_status("midreset");
    check_board("midreset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
